// File: rtl/asiclab_alu_pkg.sv
// asiclab_accum_alu shared types: operation modes, accumulator FSM states
// and the transaction counter width.
package asiclab_alu_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_CLR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_WRAPPED = 2'b10,
        ST_HOLD    = 2'b11
    } acc_state_e;

    localparam int TXN_COUNT_W = 8;

endpackage

// File: rtl/asiclab_alu_core.sv
// asiclab_accum_alu combinational datapath: add, subtract, accumulate, clear.
// ASICLAB_ACC_SATURATE_EN clamps accumulate results at all-ones on carry-out.
module asiclab_alu_core
    import asiclab_alu_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8
) (
    input  mode_e                mode,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [ACC_WIDTH-1:0] res,
    output logic                 carry,
    output logic                 wrap
);

    logic [WIDTH:0]     sum_w;
    logic [ACC_WIDTH:0] acc_sum;

    // Operation select; subtraction at full result width yields the
    // sign-extended difference directly since |a-b| < 2^WIDTH.
    always_comb begin
        res     = '0;
        carry   = 1'b0;
        wrap    = 1'b0;
        sum_w   = {1'b0, op_a} + {1'b0, op_b};
        acc_sum = {1'b0, acc}
                + (ACC_WIDTH+1)'(op_a)
                + (ACC_WIDTH+1)'(op_b);
        unique case (mode)
            MODE_ADD: begin
                res   = ACC_WIDTH'(sum_w);
                carry = sum_w[WIDTH];
            end
            MODE_SUB: begin
                res   = ACC_WIDTH'(op_a) - ACC_WIDTH'(op_b);
                carry = (op_a < op_b);
            end
            MODE_ACC: begin
                carry = acc_sum[ACC_WIDTH];
                wrap  = acc_sum[ACC_WIDTH];
`ifdef ASICLAB_ACC_SATURATE_EN
                res   = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
`else
                res   = acc_sum[ACC_WIDTH-1:0];
`endif
            end
            MODE_CLR: begin
                res   = '0;
                carry = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/asiclab_accum_alu.sv
// asiclab_accum_alu top: valid/ready handshake, result register, accumulator,
// status FSM and transaction counter. Optional macro: ASICLAB_ACC_SATURATE_EN.
module asiclab_accum_alu
    import asiclab_alu_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       op_a,
    input  logic [WIDTH-1:0]       op_b,
    input  logic [1:0]             mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   result,
    output logic                   carry,
    output logic                   overflow,
    output logic [TXN_COUNT_W-1:0] txn_count
);

    if (ACC_WIDTH < WIDTH + 1) begin : g_bad_acc_width
        $fatal(1, "asiclab_accum_alu: ACC_WIDTH must be >= WIDTH+1");
    end
    if (WIDTH < 2) begin : g_bad_width
        $fatal(1, "asiclab_accum_alu: WIDTH must be >= 2");
    end

    mode_e                  mode_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [ACC_WIDTH-1:0]   result_q;
    logic                   carry_q;
    logic                   ovf_q;
    logic                   out_valid_q;
    logic [TXN_COUNT_W-1:0] txn_q;
    logic [ACC_WIDTH-1:0]   core_res;
    logic                   core_carry;
    logic                   core_wrap;
    logic                   accept;
    logic                   consume;
    acc_state_e             status_q;
    acc_state_e             status_d;
    acc_state_e             state_q;
    acc_state_e             state_d;

    assign mode_q    = mode_e'(mode);
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign txn_count = txn_q;

    asiclab_alu_core #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_core (
        .mode  (mode_q),
        .op_a  (op_a),
        .op_b  (op_b),
        .acc   (acc_q),
        .res   (core_res),
        .carry (core_carry),
        .wrap  (core_wrap)
    );

    // Result, accumulator, flags and counter load on an accepted transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            txn_q       <= '0;
        end else begin
            if (accept) begin
                result_q <= core_res;
                carry_q  <= core_carry;
                txn_q    <= txn_q + 1'b1;
                if (mode_q == MODE_ACC) begin
                    acc_q <= core_res;
                    if (core_wrap) ovf_q <= 1'b1;
                end else if (mode_q == MODE_CLR) begin
                    acc_q <= '0;
                    ovf_q <= 1'b0;
                end
            end
            if (accept)       out_valid_q <= 1'b1;
            else if (consume) out_valid_q <= 1'b0;
        end
    end

    // Status and FSM state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= ST_IDLE;
            state_q  <= ST_IDLE;
        end else begin
            status_q <= status_d;
            state_q  <= state_d;
        end
    end

    // Status moves only on accepted ACC/CLR; a stalled output forces HOLD,
    // and the saved status is restored once the stall clears.
    always_comb begin
        status_d = status_q;
        state_d  = status_q;
        if (accept && mode_q == MODE_ACC) begin
            if (ovf_q || core_wrap)   status_d = ST_WRAPPED;
            else if (core_res != '0)  status_d = ST_RUN;
            else                      status_d = ST_IDLE;
        end else if (accept && mode_q == MODE_CLR) begin
            status_d = ST_IDLE;
        end
        if (out_valid_q && !out_ready) state_d = ST_HOLD;
        else                           state_d = status_d;
    end

`ifndef SYNTHESIS
    a_wrapped_ovf: assert property (@(posedge clk) disable iff (reset)
        state_q == ST_WRAPPED |-> ovf_q);
    a_idle_zero: assert property (@(posedge clk) disable iff (reset)
        state_q == ST_IDLE |-> (acc_q == '0 && !ovf_q));
    a_run_nonzero: assert property (@(posedge clk) disable iff (reset)
        state_q == ST_RUN |-> (acc_q != '0 && !ovf_q));
    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid_q && !out_ready) |=> $stable(result_q));
`endif

endmodule

// File: tb/tb_asiclab_accum_alu.sv
// Directed testbench for asiclab_accum_alu (WIDTH=4, ACC_WIDTH=8).
// Expectations follow ASICLAB_ACC_SATURATE_EN when it is defined.
module tb_asiclab_accum_alu;
    import asiclab_alu_pkg::*;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic [7:0] txn_count;

    int n_tests;
    int n_fail;

    asiclab_accum_alu #(
        .WIDTH     (4),
        .ACC_WIDTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [3:0] a,
                         input logic [3:0] b);
        in_valid = 1'b1;
        mode     = m;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    logic [7:0] exp_acc;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = MODE_ADD;
        op_a      = '0;
        op_b      = '0;
        step();
        step();
        reset = 1'b0;

        check("rst_result", result, 0);
        check("rst_valid", out_valid, 0);
        check("rst_txn", txn_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_carry", carry, 0);
        check("rst_in_ready", in_ready, 1);

        drive(MODE_ADD, 4'd9, 4'd8);
        step();
        check("add_result", result, 8'h11);
        check("add_carry", carry, 1);
        check("add_valid", out_valid, 1);
        check("add_txn", txn_count, 1);
        check("add_ovf", overflow, 0);

        drive(MODE_SUB, 4'd3, 4'd5);
        step();
        check("sub1_result", result, 8'hFE);
        check("sub1_borrow", carry, 1);
        drive(MODE_SUB, 4'd7, 4'd2);
        step();
        check("sub2_result", result, 8'h05);
        check("sub2_borrow", carry, 0);

        for (int i = 1; i <= 9; i++) begin
            drive(MODE_ACC, 4'd15, 4'd15);
            step();
            if (i == 8) begin
                check("acc8_result", result, 8'hF0);
                check("acc8_carry", carry, 0);
                check("acc8_ovf", overflow, 0);
            end
        end
`ifdef ASICLAB_ACC_SATURATE_EN
        exp_acc = 8'hFF;
`else
        exp_acc = 8'h0E;
`endif
        check("acc9_result", result, exp_acc);
        check("acc9_carry", carry, 1);
        check("acc9_ovf", overflow, 1);
        check("acc9_txn", txn_count, 12);

        drive(MODE_ACC, 4'd0, 4'd0);
        step();
        check("acc0_result", result, exp_acc);
        check("acc0_ovf_sticky", overflow, 1);

        drive(MODE_ADD, 4'd1, 4'd1);
        step();
        check("add_ovf_kept", overflow, 1);
        check("add_after_acc", result, 8'h02);

        drive(MODE_ACC, 4'd1, 4'd0);
        step();
`ifdef ASICLAB_ACC_SATURATE_EN
        check("acc_post_wrap", result, 8'hFF);
`else
        check("acc_post_wrap", result, 8'h0F);
`endif

        drive(MODE_CLR, 4'd3, 4'd4);
        step();
        check("clr_result", result, 0);
        check("clr_ovf", overflow, 0);
        check("clr_carry", carry, 0);
        check("clr_txn", txn_count, 16);

        do_reset();
        out_ready = 1'b0;
        drive(MODE_ADD, 4'd2, 4'd3);
        step();
        check("bp_first_result", result, 8'h05);
        check("bp_first_txn", txn_count, 1);
        drive(MODE_ADD, 4'd4, 4'd4);
        for (int i = 0; i < 2; i++) begin
            check("bp_in_ready", in_ready, 0);
            step();
            check("bp_result_hold", result, 8'h05);
            check("bp_txn_hold", txn_count, 1);
            check("bp_valid_hold", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        step();
        check("bp_next_result", result, 8'h08);
        check("bp_next_txn", txn_count, 2);

        drive(MODE_CLR, 4'd0, 4'd0);
        step();
        drive(MODE_ACC, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            op_a = 4'd8;
            op_b = 4'd8;
            step();
        end
        check("pre_rst_acc", result, 8'h40);
        out_ready = 1'b0;
        reset     = 1'b1;
        drive(MODE_ADD, 4'd1, 4'd1);
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_txn", txn_count, 0);
        check("mid_rst_result", result, 0);
        out_ready = 1'b1;
        drive(MODE_ACC, 4'd0, 4'd0);
        step();
        check("mid_rst_acc", result, 0);
        check("mid_rst_txn1", txn_count, 1);

        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive(MODE_ADD, 4'(i), 4'(i >> 4));
            step();
            check("b2b_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        check("b2b_txn_wrap", txn_count, 0);
        check("b2b_last", result, 8'h1E);
        step();
        check("drain_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/asiclab_accum_alu.md
Name: asiclab_accum_alu

Overview:
- Parametrised successor to the registered nibble adder.
- Takes two WIDTH-bit operands per transaction with a valid/ready handshake and one of four modes: add, subtract, accumulate, clear.
- Returns a registered ACC_WIDTH-bit result with carry and overflow flags.
- Sits between the pad-level input decode and the output register bank of the top-level tile.

Parameters:
- WIDTH, 4, operand width in bits (>=2).
- ACC_WIDTH, 8, result/accumulator width; must satisfy ACC_WIDTH >= WIDTH+1 (elaboration-time check, fatal).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/mode present.
- in_ready  output  1  block can accept a transaction this cycle.
- op_a  input  WIDTH  operand A, unsigned.
- op_b  input  WIDTH  operand B, unsigned.
- mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer accepts result.
- result  output  ACC_WIDTH  registered result.
- carry  output  1  carry/borrow of the accepted operation.
- overflow  output  1  sticky accumulator-wrap flag.
- txn_count  output  8  number of accepted transactions, wraps at 255->0.

Behaviour:
- Reset is synchronous: on a clk edge with reset=1, the following clear to 0: result, carry, overflow, out_valid, txn_count, and the internal accumulator acc. in_ready is combinational and therefore reads 1 after reset.
- in_ready = !out_valid || out_ready. This gives a single-entry output stage with full throughput.
- Accept = in_valid && in_ready. On accept, at the next edge: result, carry and flags load; out_valid=1; txn_count+1. Latency is 1 cycle.
- Consume = out_valid && out_ready. If consume occurs without a simultaneous accept, out_valid returns to 0 at the next edge. If accept and consume coincide, out_valid stays 1 and the new result replaces the old one.
- While out_valid=1 and out_ready=0, result, carry and overflow hold stable. Inputs are ignored and acc is unchanged.
- ADD: sum = op_a + op_b computed at WIDTH+1 bits and zero-extended to ACC_WIDTH. carry = sum[WIDTH]. acc is unchanged.
- SUB: diff = op_a - op_b as a (WIDTH+1)-bit two's complement value, sign-extended to ACC_WIDTH. carry = 1 iff op_a < op_b (borrow). acc is unchanged.
- ACC: acc_next = acc + op_a + op_b, modulo 2^ACC_WIDTH. result = acc_next. carry = carry-out of bit ACC_WIDTH-1. overflow is set to 1 if that carry-out is 1; it is sticky.
- CLR: acc is set to 0, result = 0, carry = 0, overflow is cleared. Counts as a transaction.
- overflow changes only on ACC (set) or CLR (clear). ADD and SUB leave it unchanged.
- Reset asserted mid-transaction: all state clears, and any pending result is discarded. Inputs presented in the same cycle as reset are not accepted, and txn_count is not incremented.
- Fixed 4-state FSM on acc status: IDLE (acc==0, no overflow), RUN (acc!=0), WRAPPED (overflow=1), HOLD (out_valid && !out_ready).
  - HOLD takes priority and returns to the prior status state on consume.
  - Transitions are driven only by accepted ACC/CLR operations.
  - The state is internal; it is exposed only for assertions.

Optional Feature:
- Macro ASICLAB_ACC_SATURATE_EN.
- Defined: in ACC mode, when the carry-out is 1, acc and result clamp to 2^ACC_WIDTH-1 instead of wrapping. carry=1 and overflow is set as normal. Subsequent ACC operations stay clamped until CLR.
- Undefined: modular wrap, exactly as specified above.
- ADD and SUB are unaffected in both builds.

Decomposition:
- Package asiclab_alu_pkg holds:
  - mode_e enum (MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_ACC=2'b10, MODE_CLR=2'b11).
  - acc_state_e FSM enum.
  - TXN_COUNT_W=8 constant.
- One natural sub-module: asiclab_alu_core. It is purely combinational and computes result, carry and the wrap flag from mode, operands and acc. The top holds the handshake, registers, FSM and counter.

Test Plan (WIDTH=4, ACC_WIDTH=8):
- Reset then ADD a=9, b=8, out_ready=1 -> next cycle: result=0x11, carry=1, out_valid=1, txn_count=1, overflow=0.
- SUB a=3, b=5 -> result=0xFE (-2 sign-extended), carry=1. Then SUB a=7, b=2 -> result=0x05, carry=0.
- ACC a=15, b=15 repeated 9 times (9*30=270) -> 9th result=0x0E, carry=1, overflow=1 stays sticky. CLR -> result=0, overflow=0. With ASICLAB_ACC_SATURATE_EN, 9th result=0xFF and stays 0xFF.
- Backpressure: out_ready=0 with in_valid held for 3 cycles -> only the first accepted, in_ready=0, result stable, txn_count=1. Raise out_ready -> next transaction is accepted in the same cycle.
- Reset asserted while out_valid=1 and acc=0x40 -> next edge: out_valid=0, acc=0, txn_count=0. The in_valid presented that cycle is not accepted.
- 256 back-to-back ADDs with out_ready=1 -> txn_count wraps to 0, and out_valid stays continuously 1 after the first.
